// File: rtl/pio_pkg.sv
// pio_pkg: shared definitions for the Avalon-MM edge-capturing input PIO.
//   - Register offsets on the 2-bit slave address bus.
//   - Edge-type encodings for the EDGE_TYPE parameter.
//   - edge_detect(): per-bit edge selection on 32-bit vectors.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Per-bit edge detect between the current and previous synchronized samples.
  // Unknown encodings fall back to rising-edge behaviour.
  function automatic logic [31:0] edge_detect(input logic [31:0] cur,
                                              input logic [31:0] prev,
                                              input int          edge_type);
    logic [31:0] rise_v;
    logic [31:0] fall_v;
    logic [31:0] sel_v;
    rise_v = cur & ~prev;
    fall_v = ~cur & prev;
    case (edge_type)
      EDGE_RISING:  sel_v = rise_v;
      EDGE_FALLING: sel_v = fall_v;
      EDGE_ANY:     sel_v = rise_v | fall_v;
      default:      sel_v = rise_v;
    endcase
    return sel_v;
  endfunction

endpackage

// File: rtl/pio_bit_sync.sv
// pio_bit_sync: multi-flop synchronizer bringing an asynchronous bus into clk.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset, clears every stage
//   d        in  WIDTH asynchronous inputs
//   q        out WIDTH synchronized outputs (last stage of the chain)
module pio_bit_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift chain: stage 0 samples the raw inputs, each later stage re-samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/avalon_pio_in_edge_irq.sv
// avalon_pio_in_edge_irq: Avalon-MM input PIO with sticky edge capture and a
// maskable level interrupt.
//   clk         in  system clock
//   reset_n     in  asynchronous active-low reset
//   address     in  2   0 data, 1 reserved, 2 irqmask, 3 edgecapture (W1C)
//   chipselect  in  1   slave select
//   read_n      in  1   active-low read strobe (1-cycle read latency)
//   write_n     in  1   active-low write strobe
//   writedata   in  32  write data
//   in_port     in  WIDTH asynchronous status inputs
//   readdata    out 32  registered read data, upper bits zero
//   irq         out 1   registered |(edgecapture & irqmask)
module avalon_pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Edge detection stays disabled until the chain and prev_in_r hold real samples.
  localparam logic [2:0] PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_in_s;
  logic [WIDTH-1:0] prev_in_r;
  logic [WIDTH-1:0] irqmask_r;
  logic [WIDTH-1:0] edgecap_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [2:0]       prime_cnt_r;
  logic             primed_s;
  logic             wr_s;
  logic             rd_s;
  logic [31:0]      cur_ext_s;
  logic [31:0]      prev_ext_s;
  logic [31:0]      det_ext_s;
  logic [31:0]      rd_mux_s;

  pio_bit_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_in_s)
  );

  assign wr_s     = chipselect & ~write_n;
  assign rd_s     = chipselect & ~read_n;
  assign primed_s = (prime_cnt_r == PRIME_MAX);

  // Previous synchronized sample for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_in_r <= {WIDTH{1'b0}};
    end else begin
      prev_in_r <= sync_in_s;
    end
  end

  // Prime counter: counts up after reset release and saturates at PRIME_MAX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prime_cnt_r <= 3'd0;
    end else if (!primed_s) begin
      prime_cnt_r <= prime_cnt_r + 3'd1;
    end else begin
      prime_cnt_r <= prime_cnt_r;
    end
  end

  // Edge selection on zero-extended vectors, gated off while priming.
  always_comb begin
    cur_ext_s                = 32'd0;
    prev_ext_s               = 32'd0;
    cur_ext_s[WIDTH-1:0]     = sync_in_s;
    prev_ext_s[WIDTH-1:0]    = prev_in_r;
    det_ext_s                = edge_detect(cur_ext_s, prev_ext_s, EDGE_TYPE);
    if (primed_s) begin
      edge_s = det_ext_s[WIDTH-1:0];
    end else begin
      edge_s = {WIDTH{1'b0}};
    end
  end

  // Write-1-to-clear mask for the capture register.
  always_comb begin
    if (wr_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Sticky capture: a new edge is OR-ed in after the clear, so set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap_r <= {WIDTH{1'b0}};
    end else begin
      edgecap_r <= (edgecap_r & ~clr_s) | edge_s;
    end
  end

  // Interrupt mask register; only address 2 writes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_r <= {WIDTH{1'b0}};
    end else if (wr_s && (address == ADDR_IRQMASK)) begin
      irqmask_r <= writedata[WIDTH-1:0];
    end else begin
      irqmask_r <= irqmask_r;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edgecap_r & irqmask_r);
    end
  end

  // Read mux from current (pre-write) state; upper bits stay zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      ADDR_DATA:    rd_mux_s[WIDTH-1:0] = sync_in_s;
      ADDR_RSVD:    rd_mux_s            = 32'd0;
      ADDR_IRQMASK: rd_mux_s[WIDTH-1:0] = irqmask_r;
      ADDR_EDGECAP: rd_mux_s[WIDTH-1:0] = edgecap_r;
      default:      rd_mux_s            = 32'd0;
    endcase
  end

  // Read data register, held between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else if (rd_s) begin
      readdata <= rd_mux_s;
    end else begin
      readdata <= readdata;
    end
  end

endmodule

// File: tb/tb_avalon_pio_in_edge_irq.sv
// Testbench for avalon_pio_in_edge_irq: one rising-edge instance and one
// any-edge instance share the bus and in_port.
module tb_avalon_pio_in_edge_irq;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] readdata_rise;
  logic [31:0] readdata_any;
  logic        irq_rise;
  logic        irq_any;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        is_write;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  avalon_pio_in_edge_irq #(.WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata_rise), .irq(irq_rise)
  );

  avalon_pio_in_edge_irq #(.WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(readdata_any), .irq(irq_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    tick();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  initial begin
    // Register-access table run straight after reset with all inputs high.
    vecs[0] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 32'h0000_00FF, 32'h0000_0000, 1'b0};
    vecs[5] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_00FF, 1'b0};
    vecs[6] = '{1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[8] = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_00FF, 1'b0};
    vecs[9] = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0};

    address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    writedata = 32'h0; in_port = 32'hFFFF_FFFF; reset_n = 1'b0;
    ticks(3);
    check("reset_readdata", readdata_rise, 32'h0);
    check("reset_irq", {31'd0, irq_rise}, 32'h0);
    reset_n = 1'b1;
    ticks(10);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].is_write) begin
        bus_write(vecs[v].addr, vecs[v].wdata);
      end else begin
        bus_read(vecs[v].addr);
        check($sformatf("vec%0d_rd_rise", v), readdata_rise, vecs[v].exp_rd);
        check($sformatf("vec%0d_rd_any", v), readdata_any, vecs[v].exp_rd);
      end
      check($sformatf("vec%0d_irq", v), {31'd0, irq_rise}, {31'd0, vecs[v].exp_irq});
    end

    // Read data holds when no read strobe.
    tick();
    check("readdata_hold", readdata_rise, 32'h0);

    // Rising edge on bit 0 with mask 1: irq exactly 4 cycles after the change.
    in_port = 32'h0;
    ticks(6);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h0000_0001);
    ticks(2);
    in_port = 32'h0000_0001;
    tick();
    in_port = 32'h0;
    check("irq_lat_c1", {31'd0, irq_rise}, 32'h0);
    tick();
    check("irq_lat_c2", {31'd0, irq_rise}, 32'h0);
    tick();
    check("irq_lat_c3", {31'd0, irq_rise}, 32'h0);
    tick();
    check("irq_lat_c4", {31'd0, irq_rise}, 32'h1);
    bus_read(2'd3);
    check("cap_bit0", readdata_rise, 32'h0000_0001);
    bus_write(2'd3, 32'h0000_0001);
    check("irq_at_clear", {31'd0, irq_rise}, 32'h1);
    tick();
    check("irq_after_clear", {31'd0, irq_rise}, 32'h0);
    bus_read(2'd3);
    check("cap_cleared", readdata_rise, 32'h0);

    // Masked edge on bit 5, then unmask.
    bus_write(2'd2, 32'h0);
    in_port = 32'h0000_0020;
    ticks(6);
    bus_read(2'd3);
    check("cap_bit5", readdata_rise, 32'h0000_0020);
    check("irq_masked", {31'd0, irq_rise}, 32'h0);
    bus_write(2'd2, 32'h0000_0020);
    check("irq_unmask_same", {31'd0, irq_rise}, 32'h0);
    tick();
    check("irq_unmask_next", {31'd0, irq_rise}, 32'h1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h0);
    ticks(2);

    // Edge on bit 3 lands in capture on the same edge as a W1C of bit 3.
    in_port = 32'h0000_0028;
    ticks(2);
    bus_write(2'd3, 32'h0000_0008);
    bus_read(2'd3);
    check("set_wins", readdata_rise, 32'h0000_0008);

    // Falling edge on bit 7 seen only by the any-edge instance.
    in_port = 32'h0000_00A8;
    ticks(6);
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0000_0028;
    ticks(6);
    bus_read(2'd3);
    check("any_fall_bit7", readdata_any, 32'h0000_0080);
    check("rise_ignores_fall", readdata_rise, 32'h0);
    bus_write(2'd3, 32'h0);
    bus_read(2'd3);
    check("w0_keeps_cap", readdata_any, 32'h0000_0080);
    bus_read(2'd0);
    check("data_read", readdata_any, 32'h0000_0028);

    // Reset asserted in the middle of a read.
    bus_write(2'd2, 32'h0000_00FF);
    tick();
    check("irq_any_before_rst", {31'd0, irq_any}, 32'h1);
    address = 2'd3; chipselect = 1'b1; read_n = 1'b0;
    @(posedge clk);
    #1;
    check("rd_before_rst", readdata_any, 32'h0000_0080);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_readdata", readdata_any, 32'h0);
    check("rst_async_irq", {31'd0, irq_any}, 32'h0);
    chipselect = 1'b0; read_n = 1'b1;
    ticks(2);
    reset_n = 1'b1;
    ticks(10);
    bus_read(2'd3);
    check("reprime_cap_rise", readdata_rise, 32'h0);
    check("reprime_cap_any", readdata_any, 32'h0);
    bus_read(2'd2);
    check("reprime_mask", readdata_any, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_pio_in_edge_irq.md
Name: avalon_pio_in_edge_irq

Overview:
- Avalon-MM slave input port: the HPS-readable counterpart to the write-only output PIO that drives solver parameters.
- Samples a 32-bit fabric status bus (solver done, overflow flags, VGA frame tick, ...) into the clk domain through a synchronizer.
- Latches selected edges into a sticky edge-capture register and raises a maskable interrupt to the HPS.
- Sits on the lightweight HPS-to-FPGA bridge beside the existing output PIOs.

Parameters:
- WIDTH, 32, width of in_port, data, mask and capture registers (1..32).
- EDGE_TYPE, 0, edge that sets a capture bit: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, flip-flops in each in_port bit's synchronizer (2..4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- address  in  2  register select: 0 data, 1 reserved, 2 irqmask, 3 edgecapture
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous status inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt to HPS

Behaviour:
- Reset: reset reset_n, asynchronous, active-low; clock clk. All of the following clear to 0: synchronizer flops, previous-sample register, irqmask, edgecapture, readdata, irq, prime counter.
- Synchronizer:
  - SYNC_STAGES-deep flop chain per bit gives sync_in.
  - prev_in <= sync_in every cycle.
- Priming:
  - A counter runs from 0 to SYNC_STAGES+1 after reset release and then saturates.
  - Edge detection is forced to 0 until the counter saturates, so inputs already high at reset release never set capture bits.
- Edge detect, per bit:
  - rising = sync_in & ~prev_in
  - falling = ~sync_in & prev_in
  - any = rising | falling
  - Selection is by EDGE_TYPE.
- Edge capture:
  - A detected edge sets edgecapture[i] and the bit stays set.
  - A write to address 3 clears every bit i where writedata[i] = 1 (write-1-to-clear).
  - If an edge and a clear hit the same bit in the same cycle, set wins and the bit stays 1.
- irqmask:
  - Write to address 2 loads writedata[WIDTH-1:0].
  - Writes to addresses 0 and 1 are ignored.
- irq:
  - Registered: irq <= |(edgecapture & irqmask).
  - irq goes high 1 cycle after the capture bit is set, and deasserts 1 cycle after the clear or mask write.
- Reads:
  - Read latency 1: readdata is updated on the clk edge where chipselect = 1 and read_n = 0, and is held otherwise.
  - Address 0 returns sync_in. Address 1 returns 0. Address 2 returns irqmask. Address 3 returns edgecapture.
  - Bits [31:WIDTH] always read 0.
  - Reads have no side effects; in particular a read does not clear edgecapture.
- Simultaneous read and write in one cycle: not legal on Avalon. If it occurs, the write takes effect and readdata shows the pre-write value.
- Input latency: a change on in_port is visible at address 0 after SYNC_STAGES cycles plus 1 read-latency cycle.
- Reset asserted mid-operation: all state clears immediately, irq drops asynchronously, and the prime counter restarts.

Decomposition:
- Package pio_pkg holds:
  - register offsets: ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3
  - EDGE_RISING = 0, EDGE_FALLING = 1, EDGE_ANY = 2
- One sub-module, pio_bit_sync: a SYNC_STAGES-deep, WIDTH-bit synchronizer with async reset, instantiated once.
- Edge detect, capture, registers and read mux stay in the top module.

Test Plan:
- Reset with in_port = 32'hFFFF_FFFF held high, then release and wait 10 cycles; read address 3 -> 32'h0; irq = 0; read address 0 -> 32'hFFFF_FFFF.
- EDGE_TYPE = 0, mask = 32'h1: pulse in_port[0] 0→1 for 1 cycle after priming -> read address 3 = 32'h1; irq rises exactly SYNC_STAGES+2 cycles after the in_port edge. Write 32'h1 to address 3 -> capture = 0 and irq = 0 one cycle later.
- Mask = 32'h0 and edge on bit 5 -> capture = 32'h20 and irq stays 0. Then write mask = 32'h20 -> irq = 1 on the next cycle.
- Arrange an edge on bit 3 to reach the capture register in the same cycle as a write of 32'h8 to address 3 -> read address 3 returns 32'h8.
- EDGE_TYPE = 2, in_port[7] toggles 1→0 -> capture bit 7 set. A write to address 3 with writedata = 32'h0 leaves it set.
- Read address 1 -> 32'h0. Write 32'hDEAD_BEEF to address 0 -> irqmask and capture unchanged. Assert reset_n low mid-read -> readdata = 0 and irq = 0 immediately.
